rca_sweep_checker: RTL and testbench
====================================

# rca_sweep_checker

Synthesizable stimulus-and-check stage that sits directly upstream of the 4-bit ripple-carry adder and consumes its result. On `start` it sweeps all 2^(2·WIDTH+1) combinations of `a`, `b`, `cin` into the adder, compares `{cout,sum}` after a programmable settle time, and reports per-vector errors, an error count, the first failing vector and `done`. It brings the lab's exhaustive-test flow onto the board, so it runs clocked instead of with bench delays.

## Interface
- `WIDTH`, 4: adder operand width.
- `SETTLE`, 1: cycles a vector is held before sampling (≥1).
- `clk`  in  1: the only clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: begin a sweep (sampled in IDLE/DONE only).
- `a`  out  WIDTH: operand to adder.
- `b`  out  WIDTH: operand to adder.
- `cin`  out  1: carry-in to adder.
- `dut_sum`  in  WIDTH: adder sum.
- `dut_cout`  in  1: adder carry-out.
- `error`  out  1: one-cycle pulse after a mismatching check.
- `err_count`  out  2·WIDTH+2: saturating mismatch count.
- `fail_valid`  out  1: a failure has been captured this sweep.
- `fail_vec`  out  2·WIDTH+1: first failing `{cin,b,a}`.
- `busy`  out  1: sweep in progress.
- `done`  out  1: sweep complete; held until next `start` or reset.

## Operation
- FSM states: IDLE, APPLY, CHECK, DONE.
- IDLE: outputs at reset values. `start` moves to APPLY with vector index 0.
- APPLY: drive current vector; hold for SETTLE cycles using a settle counter, then go to CHECK.
- CHECK: expected = `a + b + cin`, computed at WIDTH+1 bits, zero-extended. Compare with `{dut_cout,dut_sum}` using case-inequality (X/Z is a mismatch in simulation). On mismatch, register `error`=1 for the next cycle and increment `err_count` (saturates at all-ones). On the first mismatch of the sweep, capture `fail_vec` and set `fail_valid`. Then:
  - if the index is the last vector, go to DONE;
  - otherwise increment the index and go to APPLY.
- Vector order is `a` fastest, then `b`, then `cin`: index = `{cin,b,a}`, incremented as one counter.
- DONE: `done`=1, vector frozen at the last value. `start` clears `err_count`, `fail_valid`, `fail_vec` and `done`, then enters APPLY at index 0.
- `start` while `busy` is ignored.
- A reset mid-sweep aborts immediately and returns to the reset state.

## Timing
- Reset values:
  - `a`, `b`, `cin` = 0;
  - `error`, `err_count`, `fail_valid`, `fail_vec` = 0;
  - `busy`, `done` = 0;
  - state IDLE.
- `start` high in cycle t: `busy`=1 and vector 0 is on the outputs at t+1.
- Each vector occupies SETTLE+1 cycles (SETTLE in APPLY, 1 in CHECK). The vector is stable through CHECK.
- `error` is asserted in the cycle after the CHECK that failed. `err_count` and `fail_vec` update in that same cycle.
- A full sweep takes 512·(SETTLE+1) cycles for WIDTH=4. `done` rises in the cycle after the final CHECK, and `busy` falls in that same cycle.
- `start` and the final CHECK arriving in the same cycle: `start` is ignored.
- All outputs are registered; there is no combinational path from `dut_*` to any output.

## Structure
- Shared package `rca_test_pkg` holds:
  - the state enum (IDLE, APPLY, CHECK, DONE);
  - `VEC_BITS` = 2·WIDTH+1;
  - `CNT_BITS` = 2·WIDTH+2.
- One sub-module, `sweep_counter`: a VEC_BITS index counter with `clr`, `inc` and a `last` flag.
- The settle counter and compare logic live in the top module.

## Test plan
- Correct adder, SETTLE=1, start pulse:
  - `done` at cycle 1025 after start, `err_count`=0, `fail_valid`=0;
  - no `error` pulse during the sweep.
- Adder with `cout` stuck at 0:
  - `err_count`=256 (120 failures with cin=0, 136 with cin=1);
  - `fail_vec`={0,4'd1,4'd15}.
- Adder with `sum[0]` inverted:
  - `err_count`=512, `fail_vec`=0;
  - `error` pulses once per vector.
- `rst_n` low at cycle 300 of a sweep: all outputs 0 immediately. A new `start` then runs a full sweep to 0 errors.
- `start` pulsed mid-sweep: no restart, total length unchanged. `start` in DONE: counts clear and a second full sweep completes.
- SETTLE=3 with an adder modelled with 2-cycle output delay: 0 errors, `done` after 2048 cycles.

Source files
------------

// File: rtl/rca_test_pkg.sv
// rca_test_pkg: shared state type and sizes for the ripple-carry adder sweep checker
package rca_test_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int VEC_BITS = 2 * DEF_WIDTH + 1;
  localparam int CNT_BITS = 2 * DEF_WIDTH + 2;
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
endpackage

// File: rtl/rca_sweep_checker_sweep_counter.sv
// sweep_counter: vector index counter with clear, increment and all-ones flag
module sweep_counter import rca_test_pkg::*; #(
  parameter int N = VEC_BITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [N-1:0] o_idx,
  output logic         o_last
);
  logic [N-1:0] r_idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_idx <= '0;
    else if (i_clr) r_idx <= '0;
    else if (i_inc) r_idx <= r_idx + 1'b1;
  assign o_idx = r_idx;
  assign o_last = &r_idx;
endmodule

// File: rtl/rca_sweep_checker.sv
// rca_sweep_checker: exhaustively drives an adder and checks {cout,sum} against a+b+cin
module rca_sweep_checker import rca_test_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  output logic [WIDTH-1:0]   o_a,
  output logic [WIDTH-1:0]   o_b,
  output logic               o_cin,
  input  logic [WIDTH-1:0]   i_dut_sum,
  input  logic               i_dut_cout,
  output logic               o_error,
  output logic [2*WIDTH+1:0] o_err_count,
  output logic               o_fail_valid,
  output logic [2*WIDTH:0]   o_fail_vec,
  output logic               o_busy,
  output logic               o_done
);
  localparam int VB = 2 * WIDTH + 1;
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  state_t r_state, w_next;
  logic [SW-1:0] r_settle;
  logic [VB-1:0] w_idx;
  logic [WIDTH:0] w_exp;
  logic w_last, w_go, w_inc, w_settled, w_mis, w_check;
  logic r_error, r_fail_valid;
  logic [VB:0] r_err_count;
  logic [VB-1:0] r_fail_vec;
  sweep_counter #(.N(VB)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_go),
    .i_inc  (w_inc),
    .o_idx  (w_idx),
    .o_last (w_last)
  );
  assign {o_cin, o_b, o_a} = w_idx;
  assign w_exp = {1'b0, o_a} + {1'b0, o_b} + {{WIDTH{1'b0}}, o_cin};
  // Case inequality so an undriven or X adder output counts as a failure in simulation.
  assign w_mis = {i_dut_cout, i_dut_sum} !== w_exp;
  assign w_settled = r_settle == SW'(SETTLE - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = i_start ? APPLY : r_state;
      APPLY:      w_next = w_settled ? CHECK : APPLY;
      CHECK:      w_next = w_last ? DONE : APPLY;
      default:    w_next = IDLE;
    endcase
  end
  always_comb begin
    w_go = (r_state == IDLE || r_state == DONE) && i_start;
    w_check = r_state == CHECK;
    w_inc = w_check && !w_last;
    o_busy = r_state == APPLY || r_state == CHECK;
    o_done = r_state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_settle <= '0;
      r_error <= 1'b0;
      r_err_count <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec <= '0;
    end else begin
      r_settle <= (r_state == APPLY && !w_settled) ? r_settle + 1'b1 : '0;
      r_error <= w_check && w_mis;
      if (w_go) begin
        r_err_count <= '0;
        r_fail_valid <= 1'b0;
        r_fail_vec <= '0;
      end else if (w_check && w_mis) begin
        r_err_count <= &r_err_count ? r_err_count : r_err_count + 1'b1;
        r_fail_valid <= 1'b1;
        r_fail_vec <= r_fail_valid ? r_fail_vec : w_idx;
      end
    end
  assign o_error = r_error;
  assign o_err_count = r_err_count;
  assign o_fail_valid = r_fail_valid;
  assign o_fail_vec = r_fail_vec;
endmodule

// File: tb/tb_rca_sweep_checker.sv
// tb_rca_sweep_checker: randomized sweeps against a timing/count model of the checker
module tb_rca_sweep_checker;
  localparam int W = 4;
  localparam int N = 512;
  localparam int S = 1;
  localparam int L = N * (S + 1);
  logic clk = 0, rst_n = 0, start = 0, start3 = 0;
  logic [W-1:0] a, b, sum, a3, b3, sum3;
  logic cin, cout, cin3, cout3;
  logic err, err3, fv, fv3, busy, busy3, done, done3;
  logic [2*W+1:0] ec, ec3;
  logic [2*W:0] fvec, fvec3;
  logic [W:0] xr [N];
  logic [W:0] d1, d2;
  int checks = 0, errors = 0;
  int mode = 0, gen = 0, cyc = 0, t0 = 0, epl = 0;
  int pre_cnt [N+1];
  int pre_first [N+1];
  bit act = 0, d3_fin = 0;
  always #5 clk = ~clk;
  rca_sweep_checker #(.WIDTH(W), .SETTLE(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .o_a(a), .o_b(b), .o_cin(cin),
    .i_dut_sum(sum), .i_dut_cout(cout), .o_error(err), .o_err_count(ec),
    .o_fail_valid(fv), .o_fail_vec(fvec), .o_busy(busy), .o_done(done)
  );
  rca_sweep_checker #(.WIDTH(W), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_start(start3), .o_a(a3), .o_b(b3), .o_cin(cin3),
    .i_dut_sum(sum3), .i_dut_cout(cout3), .o_error(err3), .o_err_count(ec3),
    .o_fail_valid(fv3), .o_fail_vec(fvec3), .o_busy(busy3), .o_done(done3)
  );
  function automatic logic [W:0] adder(input int v);
    logic [W:0] r;
    r = 5'(v % 16 + (v / 16) % 16 + v / 256);
    if (mode == 1) r[W] = 1'b0;
    if (mode == 2) r[0] = ~r[0];
    if (mode == 3) r = r ^ xr[v];
    return r;
  endfunction
  always @(a or b or cin or mode or gen) {cout, sum} = adder(int'({cin, b, a}));
  always @(posedge clk) begin
    d1 <= {1'b0, a3} + {1'b0, b3} + {{W{1'b0}}, cin3};
    d2 <= d1;
  end
  assign {cout3, sum3} = d2;
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic set_mode(input int md);
    bit bad;
    mode = md;
    if (md == 3)
      for (int v = 0; v < N; v++) xr[v] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
    pre_cnt[0] = 0;
    pre_first[0] = 0;
    for (int v = 0; v < N; v++) begin
      bad = int'(adder(v)) != v % 16 + (v / 16) % 16 + v / 256;
      pre_cnt[v+1] = pre_cnt[v] + (bad ? 1 : 0);
      pre_first[v+1] = (pre_cnt[v] == 0 && bad) ? v : pre_first[v];
    end
    gen++;
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) act = 0;
    else begin
      if (start && !(act && cyc - t0 >= 1 && cyc - t0 <= L)) begin
        act = 1;
        t0 = cyc;
      end
      cyc++;
    end
  always @(negedge clk) begin
    int k, m, v, vp, e_ec, e_fvec;
    bit e_busy, e_done, e_err, e_fv;
    v = 0; e_busy = 0; e_done = 0; e_err = 0; e_fv = 0; e_ec = 0; e_fvec = 0;
    if (rst_n && act) begin
      k = cyc - t0;
      e_busy = k <= L;
      e_done = k > L;
      v = e_busy ? (k - 1) / (S + 1) : N - 1;
      m = (k - 1) / (S + 1);
      if (m > N) m = N;
      e_ec = pre_cnt[m];
      e_fv = e_ec > 0;
      e_fvec = pre_first[m];
      vp = (k - 1) / (S + 1) - 1;
      e_err = (k - 1) % (S + 1) == 0 && vp >= 0 && vp < N && pre_cnt[vp+1] != pre_cnt[vp];
    end
    if (err) epl++;
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("vector", {cin, b, a}, v);
    chk("error", err, e_err);
    chk("err_count", ec, e_ec);
    chk("fail_valid", fv, e_fv);
    chk("fail_vec", fvec, e_fvec);
  end
  task automatic run_sweep(input int md, input bit stray);
    int n;
    @(negedge clk); #1;
    set_mode(md);
    epl = 0;
    start = 1;
    n = 0;
    do begin
      @(negedge clk); n++; #1;
      start = stray && ($urandom_range(0, 99) == 0);
    end while (!done && n < L + 20);
    start = 0;
    chk("sweep_len", n, L + 1);
  endtask
  initial begin
    int n3, p3;
    wait (rst_n);
    @(negedge clk); #1 start3 = 1;
    @(negedge clk); #1 start3 = 0;
    n3 = 1;
    p3 = 0;
    while (!done3 && n3 < 2100) begin
      if (err3) p3++;
      @(negedge clk);
      n3++;
    end
    chk("s3_len", n3, 2049);
    chk("s3_err_count", ec3, 0);
    chk("s3_fail_valid", fv3, 0);
    chk("s3_pulses", p3, 0);
    d3_fin = 1;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    set_mode(0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_count", ec, 0);
    chk("rst_vector", {cin, b, a}, 0);
    run_sweep(0, 1);
    chk("good_err_count", ec, 0);
    chk("good_fail_valid", fv, 0);
    chk("good_pulses", epl, 0);
    run_sweep(1, 0);
    chk("model_cout0", pre_cnt[N], 256);
    chk("cout0_err_count", ec, 256);
    chk("cout0_fail_vec", fvec, 9'h01F);
    chk("cout0_fail_valid", fv, 1);
    run_sweep(2, 0);
    chk("sum0_err_count", ec, 512);
    chk("sum0_fail_vec", fvec, 0);
    chk("sum0_pulses", epl, 512);
    @(negedge clk); #1;
    set_mode(3);
    start = 1;
    @(negedge clk); #1 start = 0;
    repeat (299) @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_err_count", ec, 0);
    chk("abort_vector", {cin, b, a}, 0);
    chk("abort_fail_valid", fv, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    run_sweep(3, 1);
    chk("rand_err_count", ec, pre_cnt[N]);
    run_sweep(0, 0);
    chk("final_err_count", ec, 0);
    wait (d3_fin);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
